decimal_input: RTL and testbench
================================

Name: decimal_input

Overview:
- Operator-side input block: the inverse of the binary-to-BCD display path.
- Collects decimal digits from board switches via debounced pushbuttons and accumulates them into a 32-bit binary value (acc = acc*10 + digit).
- Presents the confirmed value to the processor's input instruction over a valid/ack handshake.
- entry_value feeds the display path so the operator sees the number while typing it.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz).
- MAX_DIGITS, 9, maximum digits accepted per entry; max 9 guarantees 999999999 fits in 32 bits without overflow.

Ports:
- clock  input  1  system clock, all logic rising-edge
- reset  input  1  synchronous, active-low reset
- digit  input  4  BCD digit from switches, sampled on an enter event
- enter_n  input  1  raw pushbutton, active-low, asynchronous: append digit
- confirm_n  input  1  raw pushbutton, active-low, asynchronous: commit value
- clear_n  input  1  raw pushbutton, active-low, asynchronous: discard entry
- data_ack  input  1  processor has consumed data_out
- data_out  output  32  committed binary value
- data_valid  output  1  data_out holds an unconsumed value
- entry_value  output  32  current accumulator, for display
- digit_count  output  4  digits accepted in current entry
- digit_error  output  1  one-cycle pulse: digit rejected

Behaviour:
- Reset (reset==0 at a clock edge): data_out=0, data_valid=0, entry_value=0, digit_count=0, digit_error=0, FSM=ENTRY, debouncers in released state with counters cleared.
- Each button path: 2-flop synchronizer, then stability counter.
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A released->pressed transition of the accepted level yields a one-cycle event (enter_ev, confirm_ev, clear_ev).
  - Holding a button gives exactly one event; bounces shorter than DEBOUNCE_CYCLES give none.
- State ENTRY, event priority clear > confirm > enter, one action per cycle:
  - clear_ev: entry_value=0, digit_count=0.
  - confirm_ev: data_out<=entry_value and data_valid<=1 next cycle; go to WAIT_ACK. An enter_ev in the same cycle is discarded.
    - With digit_count==0, commits 0.
    - entry_value and digit_count are retained (still displayed) until ack.
  - enter_ev with digit<=9 and digit_count<MAX_DIGITS: entry_value <= (entry_value<<3)+(entry_value<<1)+digit, digit_count+1; single-cycle update.
  - enter_ev with digit>9 or digit_count==MAX_DIGITS: no change; digit_error=1 for one cycle.
- State WAIT_ACK:
  - All button events are ignored, except clear_ev, which is also ignored so data cannot be lost.
  - data_ack==1: data_valid<=0, entry_value<=0, digit_count<=0, go to ENTRY. Response is visible the cycle after the ack edge.
- data_ack while in ENTRY (data_valid==0): ignored.
- data_out holds its value after the ack until the next confirm.
- Reset mid-debounce or mid-handshake: everything returns to reset values; a button still held through reset produces no event until it is released and pressed again.
- Arithmetic is unsigned 32-bit; the MAX_DIGITS limit makes overflow impossible.

Optional Feature:
- Macro DECIMAL_INPUT_NEGATIVE_EN.
- Defined:
  - Extra port sign (input, 1, switch: 1=negative).
  - sign is sampled on confirm_ev; if 1 and entry_value!=0, data_out = two's complement (~entry_value+1).
  - entry_value stays the magnitude.
  - Extra output entry_negative mirrors the sampled sign until ack, for a display minus indicator.
- Undefined: no sign port or entry_negative; data_out is always the unsigned magnitude.

Decomposition:
- Shared package decimal_input_pkg:
  - FSM state enum {ENTRY, WAIT_ACK}.
  - Constant DATA_WIDTH=32.
  - Constants BCD_MAX=4'd9 and MULT_TEN shift amounts (3, 1).
- Sub-module button_debouncer (param DEBOUNCE_CYCLES; ports clock, reset, button_n, pressed, press_event), instantiated three times.
- FSM and accumulator stay in decimal_input.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
1. Enter digits 1,2,3, then confirm -> entry_value=123, digit_count=3, data_out=123, data_valid=1; data_ack for one cycle -> data_valid=0, entry_value=0, digit_count=0.
2. enter_n toggles every 2 cycles for 20 cycles, then held low 10 cycles -> exactly one enter event, entry_value=digit.
3. Digit 4'hA with enter -> digit_error pulse, entry_value unchanged. Enter ten 9s -> 999999999 after nine; the tenth pulses digit_error.
4. Digits 5,7, clear, then 8, confirm -> data_out=8. confirm and clear events in the same cycle -> clear wins, data_valid stays 0.
5. In WAIT_ACK, press enter and clear -> no change to data_out/entry_value. Reset asserted while data_valid=1 -> all outputs 0, FSM=ENTRY.
6. With DECIMAL_INPUT_NEGATIVE_EN: sign=1, enter 4,2, confirm -> data_out=32'hFFFFFFD6, entry_negative=1. sign=1 with value 0 -> data_out=0.

Source files
------------

// File: rtl/decimal_input_pkg.sv
// decimal_input_pkg: shared FSM state, widths and times-ten helper for decimal_input
package decimal_input_pkg;
    typedef enum logic {ENTRY, WAIT_ACK} state_t;
    localparam int DATA_WIDTH = 32;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int MULT_TEN_HI = 3;
    localparam int MULT_TEN_LO = 1;
    function automatic logic [DATA_WIDTH-1:0] times_ten_plus(input logic [DATA_WIDTH-1:0] acc, input logic [3:0] d);
        return (acc << MULT_TEN_HI) + (acc << MULT_TEN_LO) + {{(DATA_WIDTH-4){1'b0}}, d};
    endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer plus stability counter, one-cycle event on press
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic pressed,
    output logic press_event
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync_q, sync_d;
    logic lvl_q, lvl_d, armed_q, armed_d, flip;
    logic [CW-1:0] cnt_q, cnt_d;
    // lvl_q starts "pressed" but disarmed: a button held through reset must be seen released first
    always_comb begin
        sync_d = {sync_q[0], button_n};
        flip = (sync_q[1] != lvl_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d = (sync_q[1] == lvl_q || flip) ? '0 : cnt_q + CW'(1);
        lvl_d = flip ? sync_q[1] : lvl_q;
        armed_d = armed_q | lvl_q;
    end
    assign pressed = armed_q & ~lvl_q;
    assign press_event = armed_q & lvl_q & flip;
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= 2'b11;
            lvl_q <= 1'b0;
            armed_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync_q <= sync_d;
            lvl_q <= lvl_d;
            armed_q <= armed_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/decimal_input.sv
// decimal_input: debounced decimal keypad accumulator with valid/ack handoff; DECIMAL_INPUT_NEGATIVE_EN adds sign entry
module decimal_input
    import decimal_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_DIGITS = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            digit,
    input  logic                  enter_n,
    input  logic                  confirm_n,
    input  logic                  clear_n,
`ifdef DECIMAL_INPUT_NEGATIVE_EN
    input  logic                  sign,
    output logic                  entry_negative,
`endif
    input  logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] entry_value,
    output logic [3:0]            digit_count,
    output logic                  digit_error
);
    logic enter_ev, confirm_ev, clear_ev;
    logic [2:0] held_unused;
    state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, dout_q, dout_d, commit;
    logic [3:0] cnt_q, cnt_d;
    logic valid_q, valid_d, err_q, err_d;
    logic neg_q, neg_d, neg_in;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clock(clock), .reset(reset), .button_n(enter_n), .pressed(held_unused[0]), .press_event(enter_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
        .clock(clock), .reset(reset), .button_n(confirm_n), .pressed(held_unused[1]), .press_event(confirm_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clock(clock), .reset(reset), .button_n(clear_n), .pressed(held_unused[2]), .press_event(clear_ev));

`ifdef DECIMAL_INPUT_NEGATIVE_EN
    assign neg_in = sign;
    assign commit = (sign && acc_q != '0) ? ~acc_q + DATA_WIDTH'(1) : acc_q;
    assign entry_negative = neg_q;
`else
    assign neg_in = 1'b0;
    assign commit = acc_q;
`endif

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        dout_d = dout_q;
        valid_d = valid_q;
        neg_d = neg_q;
        err_d = 1'b0;
        if (state_q == ENTRY) begin
            if (clear_ev) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (confirm_ev) begin
                dout_d = commit;
                valid_d = 1'b1;
                neg_d = neg_in;
                state_d = WAIT_ACK;
            end else if (enter_ev) begin
                if (digit <= BCD_MAX && cnt_q < 4'(MAX_DIGITS)) begin
                    acc_d = times_ten_plus(acc_q, digit);
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (data_ack) begin
            // all buttons, clear included, are ignored until the value is taken
            valid_d = 1'b0;
            acc_d = '0;
            cnt_d = '0;
            neg_d = 1'b0;
            state_d = ENTRY;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ENTRY;
            acc_q <= '0;
            cnt_q <= '0;
            dout_q <= '0;
            valid_q <= 1'b0;
            neg_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dout_q <= dout_d;
            valid_q <= valid_d;
            neg_q <= neg_d;
            err_q <= err_d;
        end
    end

    assign data_out = dout_q;
    assign data_valid = valid_q;
    assign entry_value = acc_q;
    assign digit_count = cnt_q;
    assign digit_error = err_q;
endmodule

// File: tb/tb_decimal_input.sv
// tb_decimal_input: directed self-checking bench for decimal_input with a short debounce window
module tb_decimal_input;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [3:0] digit = 4'd0;
    logic enter_n = 1'b1, confirm_n = 1'b1, clear_n = 1'b1, data_ack = 1'b0;
    logic [31:0] data_out, entry_value;
    logic data_valid, digit_error;
    logic [3:0] digit_count;
`ifdef DECIMAL_INPUT_NEGATIVE_EN
    logic sign = 1'b0;
    logic entry_negative;
`endif
    int total = 0, bad = 0, errs = 0, e0;

    decimal_input #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(9)) dut (
        .clock(clock), .reset(reset), .digit(digit),
        .enter_n(enter_n), .confirm_n(confirm_n), .clear_n(clear_n),
`ifdef DECIMAL_INPUT_NEGATIVE_EN
        .sign(sign), .entry_negative(entry_negative),
`endif
        .data_ack(data_ack), .data_out(data_out), .data_valid(data_valid),
        .entry_value(entry_value), .digit_count(digit_count), .digit_error(digit_error));

    always #5 clock = ~clock;
    always @(posedge clock) if (digit_error) errs <= errs + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [2:0] m);
        {clear_n, confirm_n, enter_n} = ~m;
        cycles(10);
        {clear_n, confirm_n, enter_n} = 3'b111;
        cycles(10);
    endtask

    task automatic key(input logic [3:0] d);
        digit = d;
        press(3'b001);
    endtask

    task automatic ack;
        data_ack = 1'b1;
        cycles(1);
        data_ack = 1'b0;
        cycles(1);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(10);
    endtask

    initial begin
        do_reset();
        check("rst_dout", data_out, 0);
        check("rst_valid", {31'd0, data_valid}, 0);
        check("rst_entry", entry_value, 0);
        check("rst_count", {28'd0, digit_count}, 0);
        check("rst_err", {31'd0, digit_error}, 0);

        key(4'd1); key(4'd2); key(4'd3);
        check("t1_entry", entry_value, 123);
        check("t1_count", {28'd0, digit_count}, 3);
        press(3'b010);
        check("t1_dout", data_out, 123);
        check("t1_valid", {31'd0, data_valid}, 1);
        check("t1_entry_held", entry_value, 123);
        ack();
        check("t1_ack_valid", {31'd0, data_valid}, 0);
        check("t1_ack_entry", entry_value, 0);
        check("t1_ack_count", {28'd0, digit_count}, 0);
        check("t1_dout_hold", data_out, 123);

        data_ack = 1'b1; cycles(2); data_ack = 1'b0; cycles(1);
        check("idle_ack_valid", {31'd0, data_valid}, 0);
        key(4'd4);
        data_ack = 1'b1; cycles(2); data_ack = 1'b0; cycles(1);
        check("idle_ack_entry", entry_value, 4);
        press(3'b100);
        check("clr_entry", entry_value, 0);

        digit = 4'd5;
        for (int i = 0; i < 10; i++) begin
            enter_n = ~enter_n;
            cycles(2);
        end
        enter_n = 1'b0; cycles(10); enter_n = 1'b1; cycles(10);
        check("t2_entry", entry_value, 5);
        check("t2_count", {28'd0, digit_count}, 1);
        press(3'b100);

        e0 = errs;
        key(4'hA);
        check("t3_bad_err", errs, e0 + 1);
        check("t3_bad_entry", entry_value, 0);
        for (int i = 0; i < 9; i++) key(4'd9);
        check("t3_nine_entry", entry_value, 32'h3B9AC9FF);
        check("t3_nine_count", {28'd0, digit_count}, 9);
        check("t3_nine_err", errs, e0 + 1);
        key(4'd9);
        check("t3_ten_err", errs, e0 + 2);
        check("t3_ten_entry", entry_value, 32'h3B9AC9FF);
        check("t3_ten_count", {28'd0, digit_count}, 9);
        press(3'b100);

        key(4'd5); key(4'd7);
        press(3'b100);
        check("t4_clr_entry", entry_value, 0);
        key(4'd8);
        press(3'b010);
        check("t4_dout", data_out, 8);
        check("t4_valid", {31'd0, data_valid}, 1);
        ack();
        key(4'd2);
        press(3'b110);
        check("t4_both_valid", {31'd0, data_valid}, 0);
        check("t4_both_entry", entry_value, 0);
        check("t4_both_dout", data_out, 8);

        press(3'b010);
        check("zero_valid", {31'd0, data_valid}, 1);
        check("zero_dout", data_out, 0);
        ack();

        key(4'd6);
        press(3'b010);
        digit = 4'd3;
        press(3'b001);
        press(3'b100);
        press(3'b101);
        check("t5_wait_dout", data_out, 6);
        check("t5_wait_entry", entry_value, 6);
        check("t5_wait_count", {28'd0, digit_count}, 1);
        check("t5_wait_valid", {31'd0, data_valid}, 1);
        do_reset();
        check("t5_rst_dout", data_out, 0);
        check("t5_rst_valid", {31'd0, data_valid}, 0);
        check("t5_rst_entry", entry_value, 0);
        check("t5_rst_count", {28'd0, digit_count}, 0);

        digit = 4'd7;
        enter_n = 1'b0;
        cycles(2);
        reset = 1'b0; cycles(3); reset = 1'b1;
        cycles(15);
        check("held_rst_count", {28'd0, digit_count}, 0);
        enter_n = 1'b1;
        cycles(10);
        key(4'd7);
        check("held_rst_entry", entry_value, 7);
        press(3'b100);

`ifdef DECIMAL_INPUT_NEGATIVE_EN
        sign = 1'b1;
        key(4'd4); key(4'd2);
        press(3'b010);
        check("t6_neg_dout", data_out, 32'hFFFFFFD6);
        check("t6_neg_flag", {31'd0, entry_negative}, 1);
        check("t6_neg_entry", entry_value, 42);
        ack();
        check("t6_neg_ack", {31'd0, entry_negative}, 0);
        press(3'b010);
        check("t6_zero_dout", data_out, 0);
        ack();
        sign = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
